// File: rtl/pwm_pkg.sv
// Shared types and defaults for the PWM timebase and configuration sequencer.
package pwm_pkg;

    localparam int unsigned CNT_W_DEF   = 16;
    localparam int unsigned PRESC_W_DEF = 8;
    localparam int unsigned FUNC_W_DEF  = 8;

    // Bit positions inside the functions field, interpreted by the PWM generator.
    localparam int unsigned FUNC_ALIGN_RIGHT = 0;
    localparam int unsigned FUNC_UNALIGNED   = 1;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StRun      = 2'd1,
        StStopping = 2'd2
    } state_t;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider producing one tick every (presc + 1) cycles while the timer runs.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int unsigned PRESC_W = PRESC_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_run,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    // A presc value lowered below the running count also ticks, forcing an immediate wrap.
    assign o_tick = i_run && (r_cnt >= i_presc);

    // Division counter; held at zero whenever the timer is idle or being cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (!i_run || i_clear || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_timer_ctrl.sv
// PWM timebase: run/stop/one-shot sequencing, counter ramp and double-buffered configuration.
module pwm_timer_ctrl
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = CNT_W_DEF,
    parameter int unsigned PRESC_W = PRESC_W_DEF,
    parameter int unsigned FUNC_W  = FUNC_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_en,
    input  logic               i_oneshot,
    input  logic [PRESC_W-1:0] i_presc,
    input  logic               i_cfg_wr,
    input  logic [CNT_W-1:0]   i_period_sh,
    input  logic [CNT_W-1:0]   i_compare1_sh,
    input  logic [CNT_W-1:0]   i_compare2_sh,
    input  logic [FUNC_W-1:0]  i_functions_sh,
    input  logic               i_cnt_clr,
    output logic [CNT_W-1:0]   o_count_val,
    output logic [CNT_W-1:0]   o_period,
    output logic [CNT_W-1:0]   o_compare1,
    output logic [CNT_W-1:0]   o_compare2,
    output logic [FUNC_W-1:0]  o_functions,
    output logic               o_pwm_en,
    output logic               o_upd_evt,
    output logic               o_ovf_irq,
    output logic               o_pending,
    output logic               o_done
);

    state_t r_state, w_state_nxt;

    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  r_period, r_cmp1, r_cmp2;
    logic [FUNC_W-1:0] r_func;
    logic [CNT_W-1:0]  r_stg_period, r_stg_cmp1, r_stg_cmp2;
    logic [FUNC_W-1:0] r_stg_func;
    logic              r_pending;
    logic              r_oneshot;
    logic              r_block;   // one-shot finished; wait for en to fall before restarting
    logic              r_pwm_en, r_upd_evt, r_ovf_irq, r_done;

    logic w_running, w_tick, w_clr, w_wrap, w_done, w_start;

    assign w_running = (r_state != StIdle);
    assign w_clr     = w_running && i_cnt_clr;
    // A clear outranks the wrap: no overflow, no config transfer, no wrap-driven transition.
    assign w_wrap    = w_tick && !w_clr && (r_count == r_period);
    assign w_done    = w_wrap && r_oneshot;
    assign w_start   = (r_state == StIdle) && i_en && !r_block;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_clr),
        .i_run   (w_running),
        .i_presc (i_presc),
        .o_tick  (w_tick)
    );

    // Next-state decode: one-shot completion first, then en level, then graceful-stop wrap.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_start) w_state_nxt = StRun;
            end
            StRun: begin
                if (w_done)     w_state_nxt = StIdle;
                else if (!i_en) w_state_nxt = StStopping;
            end
            StStopping: begin
                if (w_done)      w_state_nxt = StIdle;
                else if (i_en)   w_state_nxt = StRun;
                else if (w_wrap) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // State register plus the run-control flags and status pulses derived from it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= StIdle;
            r_pwm_en  <= 1'b0;
            r_done    <= 1'b0;
            r_oneshot <= 1'b0;
            r_block   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pwm_en <= (w_state_nxt != StIdle);
            r_done   <= w_done;
            if (w_start) r_oneshot <= i_oneshot;
            if (w_done)     r_block <= 1'b1;
            else if (!i_en) r_block <= 1'b0;
        end
    end

    // Counter ramp: zero when idle, cleared, wrapping or leaving the run; else step on tick.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count   <= '0;
            r_ovf_irq <= 1'b0;
        end else begin
            r_ovf_irq <= w_wrap;
            if (!w_running || w_clr || w_wrap || (w_state_nxt == StIdle)) begin
                r_count <= '0;
            end else if (w_tick) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    // Double-buffered configuration: direct load when idle or on a wrap, otherwise stage.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_period     <= '0;
            r_cmp1       <= '0;
            r_cmp2       <= '0;
            r_func       <= '0;
            r_stg_period <= '0;
            r_stg_cmp1   <= '0;
            r_stg_cmp2   <= '0;
            r_stg_func   <= '0;
            r_pending    <= 1'b0;
            r_upd_evt    <= 1'b0;
        end else begin
            r_upd_evt <= 1'b0;
            if (i_cfg_wr && (!w_running || w_wrap)) begin
                r_period  <= i_period_sh;
                r_cmp1    <= i_compare1_sh;
                r_cmp2    <= i_compare2_sh;
                r_func    <= i_functions_sh;
                r_pending <= 1'b0;
                r_upd_evt <= 1'b1;
            end else if (i_cfg_wr) begin
                r_stg_period <= i_period_sh;
                r_stg_cmp1   <= i_compare1_sh;
                r_stg_cmp2   <= i_compare2_sh;
                r_stg_func   <= i_functions_sh;
                r_pending    <= 1'b1;
            end else if (w_wrap && r_pending) begin
                r_period  <= r_stg_period;
                r_cmp1    <= r_stg_cmp1;
                r_cmp2    <= r_stg_cmp2;
                r_func    <= r_stg_func;
                r_pending <= 1'b0;
                r_upd_evt <= 1'b1;
            end
        end
    end

    assign o_count_val = r_count;
    assign o_period    = r_period;
    assign o_compare1  = r_cmp1;
    assign o_compare2  = r_cmp2;
    assign o_functions = r_func;
    assign o_pwm_en    = r_pwm_en;
    assign o_upd_evt   = r_upd_evt;
    assign o_ovf_irq   = r_ovf_irq;
    assign o_pending   = r_pending;
    assign o_done      = r_done;

endmodule

// File: doc/pwm_timer_ctrl.md
Name: pwm_timer_ctrl

Overview:
Timebase and configuration sequencer for the PWM generator datapath. It produces the `count_val` ramp, the active configuration (`period`, `compare1`, `compare2`, `functions`) and the `pwm_en` enable that drive the PWM generator. Software configuration is double-buffered: shadow values are written at any time but take effect only on a period wrap, so the PWM output never glitches mid-period. The block also handles the prescaler, one-shot mode and graceful stop.

Parameters:
- CNT_W, 16, width of counter, period and compare values
- PRESC_W, 8, width of the prescaler divide value
- FUNC_W, 8, width of the functions field

Ports:
- clk  in  1  block clock
- rst  in  1  reset; synchronous, active-high
- en  in  1  run request; level-sensitive
- oneshot  in  1  sampled on the start edge; run exactly one period, then stop
- presc  in  PRESC_W  tick every presc+1 clk cycles
- cfg_wr  in  1  one-cycle strobe; capture the shadow inputs below
- period_sh  in  CNT_W  shadow period
- compare1_sh  in  CNT_W  shadow compare1
- compare2_sh  in  CNT_W  shadow compare2
- functions_sh  in  FUNC_W  shadow functions
- cnt_clr  in  1  one-cycle strobe; restart the current period
- count_val  out  CNT_W  counter value to the PWM generator
- period  out  CNT_W  active period
- compare1  out  CNT_W  active compare1
- compare2  out  CNT_W  active compare2
- functions  out  FUNC_W  active functions
- pwm_en  out  1  high in RUN and STOPPING
- upd_evt  out  1  one-cycle pulse when staged configuration becomes active
- ovf_irq  out  1  one-cycle pulse on every counter wrap
- pending  out  1  staged configuration not yet applied
- done  out  1  one-cycle pulse on one-shot completion

Behaviour:
- Reset: every output is 0; prescaler count 0; staging registers 0; state IDLE. Reset overrides all other inputs.
- States: IDLE, RUN, STOPPING. All transitions are registered.
- Transitions:
  - IDLE→RUN on the edge where en=1. `count_val`=0 and prescaler=0 in the first RUN cycle. The one-shot flag is latched from `oneshot` on this same edge.
  - RUN→STOPPING when en=0 in RUN.
  - STOPPING→RUN when en returns to 1 before the wrap. The counter is not disturbed.
  - STOPPING→IDLE on the next wrap.
  - RUN with the one-shot flag set →IDLE on the first wrap. `done`=1 for that cycle.
  - On entering IDLE: `count_val`=0, `pwm_en`=0 in the same cycle.
- Prescaler:
  - Counts 0..presc. A tick occurs in the cycle where prescaler==presc; the prescaler then returns to 0.
  - presc=0 gives a tick every cycle.
  - A change to `presc` takes effect immediately. If prescaler>presc, the prescaler wraps to 0 with a tick.
- Counter (RUN or STOPPING only, on tick):
  - If `count_val`==`period`: wrap to 0 and pulse `ovf_irq`.
  - Otherwise increment by 1.
  - `period`=0: the counter stays at 0 and every tick is a wrap.
  - Arithmetic is modulo 2^CNT_W and unsigned.
- Configuration:
  - `cfg_wr` in IDLE: shadow inputs load into the active registers on that edge. `upd_evt`=1, `pending` stays 0.
  - `cfg_wr` in RUN or STOPPING: shadow inputs load into staging and `pending`=1. A later `cfg_wr` overwrites staging (last write wins).
  - On a wrap with `pending`=1: staging→active, `pending`=0, `upd_evt`=1, all in the same cycle as `ovf_irq`. The new `period` governs the following period.
  - `cfg_wr` coincident with a wrap: the shadow inputs go directly to active (newest data wins), `pending`=0, `upd_evt`=1.
- `cnt_clr`:
  - `count_val`=0 and prescaler=0 on the next edge.
  - No `ovf_irq`, no transfer of staged configuration, state unchanged.
  - Priority: rst > cnt_clr > wrap/increment.
  - `cnt_clr` in IDLE has no effect.
- Pass-through: compare values greater than `period` are passed through unchanged; the PWM generator decides their meaning.
- Latency: `count_val`, the active registers and `pwm_en` are registered outputs. The generator sees a new period value 1 cycle after the wrap edge.

Decomposition:
- Package `pwm_pkg`:
  - `state_t` enum {IDLE, RUN, STOPPING}
  - CNT_W, PRESC_W, FUNC_W defaults
  - functions bit indices: FUNC_ALIGN_RIGHT=0, FUNC_UNALIGNED=1
- Sub-module `pwm_prescaler`: inputs clk, rst, clear, run, presc; output tick.
- State machine, counter and shadow logic stay in the top module.

Test Plan:
- Free run: rst, cfg_wr in IDLE (period=4, presc=0), en=1 → `count_val` runs 0,1,2,3,4,0…; `ovf_irq` one cycle at each 4→0; `pwm_en`=1.
- Prescale: period=2, presc=2 → each count value held 3 cycles; wrap every 9 cycles.
- Shadow update: running period=9; at count=3 cfg_wr with period_sh=5 → `pending`=1; `period` stays 9 until the 9→0 wrap; then `upd_evt`+`ovf_irq` in the same cycle; next wrap at 5.
- Graceful stop and resume: drop en at count=2 (period=6) → `pwm_en` stays 1 and counting continues to 6, then IDLE with `count_val`=0. Repeat, but raise en at count=4 → no stop, uninterrupted count.
- One-shot: oneshot=1, period=3, en held high → a single 0..3 sequence, `done`=1 at the wrap, IDLE after, no restart until en falls and rises.
- Corner cases:
  - cfg_wr coincident with a wrap → shadow values active the next cycle.
  - cnt_clr at count=5 → `count_val`=0, no `ovf_irq`, `pending` still 1.
  - rst asserted mid-run → all outputs 0 on the next edge.
